grf: RTL and testbench

General-purpose register file for the MIPS core: 32 × 32-bit registers with two combinational read ports and one synchronous write port. It sits directly downstream of instruction fetch. The rs and rt fields of the fetched instruction (instr[25:21], instr[20:16]) drive the read addresses. The write port is fed by the write-back path, including the link value PC+4 for jal. It also produces a registered write-trace record used by the test bench to compare against the golden MARS log.

---
 rtl/grf_pkg.sv | 14 +
 rtl/grf.sv | 103 ++++++++++
 tb/tb_grf.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/grf_pkg.sv
// Shared constants for the general-purpose register file: register count,
// special register indices, widths and the write-log format string.
package grf_pkg;

   localparam int REG_NUM  = 32;
   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 31;
   localparam int ADDR_W   = 5;
   localparam int REG_W    = 32;

   // Matches the golden MARS write log: pc, destination index, value.
   localparam string LOG_FMT = "@%08h: $%2d <= %08h";

endpackage

// File: rtl/grf.sv
// MIPS register file: 32 x 32-bit, two combinational read ports, one
// synchronous write port and a registered write-trace record.
// Optional macro GRF_BYPASS_EN forwards the write data to a matching read port.
module grf
   import grf_pkg::*;
#(
   parameter int P_REG_W  = REG_W,
   parameter int P_ADDR_W = ADDR_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [P_ADDR_W-1:0] a1,
   input  logic [P_ADDR_W-1:0] a2,
   input  logic [P_ADDR_W-1:0] a3,
   input  logic                we,
   input  logic [P_REG_W-1:0]  wd,
   input  logic [P_REG_W-1:0]  pc,
   output logic [P_REG_W-1:0]  rd1,
   output logic [P_REG_W-1:0]  rd2,
   output logic                trace_valid,
   output logic [P_REG_W-1:0]  trace_pc,
   output logic [P_ADDR_W-1:0] trace_addr,
   output logic [P_REG_W-1:0]  trace_data
);

   // Register 0 has no storage; it is hard-wired to zero on the read side.
   logic [P_REG_W-1:0] regs_q [1:REG_NUM-1];
   logic [P_REG_W-1:0] regs_d [1:REG_NUM-1];

   logic               commit;
   logic               trace_valid_q, trace_valid_d;
   logic [P_REG_W-1:0] trace_pc_q,    trace_pc_d;
   logic [P_ADDR_W-1:0] trace_addr_q, trace_addr_d;
   logic [P_REG_W-1:0] trace_data_q,  trace_data_d;

   assign commit = !reset && we && (a3 != '0);

   genvar gi;
   generate
      for (gi = 1; gi < REG_NUM; gi++) begin : g_reg
         always_comb begin
            regs_d[gi] = regs_q[gi];
            if (commit && (a3 == P_ADDR_W'(gi))) begin
               regs_d[gi] = wd;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               regs_q[gi] <= '0;
            end else begin
               regs_q[gi] <= regs_d[gi];
            end
         end
      end
   endgenerate

   always_comb begin
      rd1 = (a1 == '0) ? '0 : regs_q[a1];
      rd2 = (a2 == '0) ? '0 : regs_q[a2];
`ifdef GRF_BYPASS_EN
      // commit already excludes reset and index 0, so a match implies a real write.
      if (commit && (a3 == a1)) begin
         rd1 = wd;
      end
      if (commit && (a3 == a2)) begin
         rd2 = wd;
      end
`endif
   end

   always_comb begin
      trace_valid_d = commit;
      trace_pc_d    = trace_pc_q;
      trace_addr_d  = trace_addr_q;
      trace_data_d  = trace_data_q;
      if (commit) begin
         trace_pc_d   = pc;
         trace_addr_d = a3;
         trace_data_d = wd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         trace_valid_q <= 1'b0;
         trace_pc_q    <= '0;
         trace_addr_q  <= '0;
         trace_data_q  <= '0;
      end else begin
         trace_valid_q <= trace_valid_d;
         trace_pc_q    <= trace_pc_d;
         trace_addr_q  <= trace_addr_d;
         trace_data_q  <= trace_data_d;
      end
   end

   assign trace_valid = trace_valid_q;
   assign trace_pc    = trace_pc_q;
   assign trace_addr  = trace_addr_q;
   assign trace_data  = trace_data_q;

endmodule

// File: tb/tb_grf.sv
// Directed bench for grf: reset sweep, writes, register zero, link write,
// same-cycle read/write and reset-over-write priority. Prints the write log.
module tb_grf;
   import grf_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  a1, a2, a3;
   logic        we;
   logic [31:0] wd, pc;
   logic [31:0] rd1, rd2;
   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [4:0]  trace_addr;
   logic [31:0] trace_data;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_same;

   grf dut (
      .clk         (clk),
      .reset       (reset),
      .a1          (a1),
      .a2          (a2),
      .a3          (a3),
      .we          (we),
      .wd          (wd),
      .pc          (pc),
      .rd1         (rd1),
      .rd2         (rd2),
      .trace_valid (trace_valid),
      .trace_pc    (trace_pc),
      .trace_addr  (trace_addr),
      .trace_data  (trace_data)
   );

   always #5 clk = ~clk;

   // Log line per committed write, seen one cycle after the write edge.
   always @(negedge clk) begin
      if (trace_valid === 1'b1) begin
         $display("%0t %s", $time, $sformatf(LOG_FMT, trace_pc, trace_addr, trace_data));
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd = '0; pc = '0;
      step();
      reset = 1'b0;

      // Reset then read sweep
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i); a2 = 5'(31 - i);
         #1;
         chk($sformatf("reset_rd1_%0d", i), rd1, 32'h0);
         chk($sformatf("reset_rd2_%0d", 31 - i), rd2, 32'h0);
      end
      chk("reset_trace_valid", {31'b0, trace_valid}, 32'h0);
      chk("reset_trace_pc",    trace_pc, 32'h0);
      chk("reset_trace_addr",  {27'b0, trace_addr}, 32'h0);
      chk("reset_trace_data",  trace_data, 32'h0);

      // Basic write
      we = 1'b1; a3 = 5'd8; wd = 32'h1234_5678; pc = 32'h0000_3000;
      step();
      we = 1'b0; a1 = 5'd8; #1;
      chk("basic_rd1",         rd1, 32'h1234_5678);
      chk("basic_trace_valid", {31'b0, trace_valid}, 32'h1);
      chk("basic_trace_pc",    trace_pc, 32'h0000_3000);
      chk("basic_trace_addr",  {27'b0, trace_addr}, 32'd8);
      chk("basic_trace_data",  trace_data, 32'h1234_5678);
      step();
      chk("pulse_end_valid",   {31'b0, trace_valid}, 32'h0);
      chk("trace_hold_data",   trace_data, 32'h1234_5678);

      // Register zero write is discarded
      we = 1'b1; a3 = 5'd0; wd = 32'hFFFF_FFFF; pc = 32'h0000_3004;
      step();
      we = 1'b0; a1 = 5'd0; #1;
      chk("zero_rd1",          rd1, 32'h0);
      chk("zero_trace_valid",  {31'b0, trace_valid}, 32'h0);
      chk("zero_trace_pc",     trace_pc, 32'h0000_3000);
      chk("zero_trace_data",   trace_data, 32'h1234_5678);

      // Link write to $31
      we = 1'b1; a3 = 5'd31; wd = 32'h0000_3008; pc = 32'h0000_3004;
      step();
      we = 1'b0; a2 = 5'd31; #1;
      chk("link_rd2",          rd2, 32'h0000_3008);
      chk("link_trace_addr",   {27'b0, trace_addr}, 32'd31);
      chk("link_trace_valid",  {31'b0, trace_valid}, 32'h1);

      // Same-cycle read/write, preceded by a back-to-back write of R5=1
      we = 1'b1; a3 = 5'd5; wd = 32'h0000_0001; pc = 32'h0000_3010;
      step();
      chk("b2b_first_valid",   {31'b0, trace_valid}, 32'h1);
      a3 = 5'd5; a1 = 5'd5; a2 = 5'd8; wd = 32'hA5A5_A5A5; pc = 32'h0000_3014;
      #1;
`ifdef GRF_BYPASS_EN
      exp_same = 32'hA5A5_A5A5;
`else
      exp_same = 32'h0000_0001;
`endif
      chk("same_cycle_rd1",    rd1, exp_same);
      chk("other_port_rd2",    rd2, 32'h1234_5678);
      step();
      we = 1'b0; #1;
      chk("b2b_second_valid",  {31'b0, trace_valid}, 32'h1);
      chk("b2b_second_pc",     trace_pc, 32'h0000_3014);
      chk("next_cycle_rd1",    rd1, 32'hA5A5_A5A5);

      // Reset wins over a pending write, and suppresses any bypass
      reset = 1'b1; we = 1'b1; a3 = 5'd3; a1 = 5'd3; wd = 32'h0000_0007; pc = 32'h0000_3020;
      #1;
      chk("reset_no_bypass",   rd1, 32'h0);
      step();
      reset = 1'b0; we = 1'b0; a2 = 5'd8; #1;
      chk("rst_wr_rd1",        rd1, 32'h0);
      chk("rst_wr_valid",      {31'b0, trace_valid}, 32'h0);
      chk("rst_clear_rd2",     rd2, 32'h0);
      chk("rst_clear_trpc",    trace_pc, 32'h0);

      // Ordinary write after reset is accepted again
      we = 1'b1; a3 = 5'd3; wd = 32'h0000_0007; pc = 32'h0000_3024;
      step();
      we = 1'b0; #1;
      chk("post_rst_rd1",      rd1, 32'h0000_0007);
      chk("post_rst_trdata",   trace_data, 32'h0000_0007);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
